link_fifo_bridge: RTL and testbench
===================================

Name: link_fifo_bridge

Overview:
- Host-side feeder/consumer for connection_module; sits directly upstream of its register interface.
- Buffers outgoing bytes in a TX FIFO, issues start commands (cmd_reg[0]) one byte at a time while respecting busy (status_reg[0]).
- Drains received bytes signalled by the data-update flag (status_reg[1]) into an RX FIFO and acknowledges them via cmd_reg[1].

Parameters:
DATA_WIDTH, 8, byte width on host and link data paths
REG_WIDTH, 8, width of cmd/status/prescale registers
ADDR_WIDTH, 3, FIFO address bits; each FIFO holds 2**ADDR_WIDTH entries (default 8)
START_TO, 16, cycles to wait for busy to rise after start before aborting

Ports:
clk_i  in  1  system clock
reset_i  in  1  reset
tx_data_i  in  DATA_WIDTH  byte to transmit
tx_wr_i  in  1  push tx_data_i into TX FIFO
tx_full_o  out  1  TX FIFO full
rx_data_o  out  DATA_WIDTH  RX FIFO head (first-word fall-through)
rx_rd_i  in  1  pop RX FIFO head
rx_empty_o  out  1  RX FIFO empty
rx_ovf_o  out  1  sticky: received byte dropped because RX FIFO was full
tx_err_o  out  1  sticky: start timed out; byte discarded
err_clr_i  in  1  clears rx_ovf_o and tx_err_o
prescale_i  in  REG_WIDTH  bit-rate prescaler from host
pre_reg_o  out  REG_WIDTH  to connection_module pre_reg_i
cmd_reg_o  out  REG_WIDTH  to connection_module cmd_reg_i
status_reg_i  in  REG_WIDTH  from connection_module status_reg_o
link_data_o  out  DATA_WIDTH  to connection_module data_i
link_data_i  in  DATA_WIDTH  from connection_module data_o

Behaviour:
- One clock, clk_i. Reset is synchronous, active-high on reset_i. All state updates occur on rising clk_i.
- Reset values:
  - FIFOs empty: tx_full_o=0, rx_empty_o=1, rx_data_o=0.
  - rx_ovf_o=0, tx_err_o=0, cmd_reg_o=0, link_data_o=0, pre_reg_o=0.
  - Both FSMs in IDLE; synchronizers cleared.
- Reset mid-operation: the in-flight byte is abandoned and cmd bits drop on the next edge.
- pre_reg_o is a register: it equals prescale_i delayed by one cycle.
- cmd_reg_o[7:2] is always 0.
- Synchronizers: status_reg_i[0] (busy) and status_reg_i[1] (upd) each pass through two flops, giving busy_s and upd_s. Decisions use only the synchronized values.
- FIFO rules (both FIFOs):
  - Circular, with ADDR_WIDTH+1-bit pointers; wrap is silent.
  - A push while full is ignored, even if a pop occurs in the same cycle.
  - A pop while empty is ignored.
  - Simultaneous push and pop when not full and not empty: occupancy is unchanged.
  - rx_data_o updates the cycle after a pop or after the first push into an empty FIFO.
- TX FSM:
  - T_IDLE: if TX FIFO not empty and busy_s=0 -> pop the head into link_data_o, go to T_START.
  - T_START: cmd_reg_o[0]=1 and a timeout counter increments.
    - If busy_s=1 -> cmd_reg_o[0]=0, go to T_WAIT.
    - Else if the counter reaches START_TO -> cmd_reg_o[0]=0, tx_err_o=1, go to T_IDLE.
  - T_WAIT: when busy_s=0 -> go to T_IDLE.
  - link_data_o holds stable from T_START entry until the next pop.
  - Minimum 1-cycle gap between successive start pulses.
- RX FSM:
  - R_IDLE: if upd_s=1 -> go to R_CAP.
  - R_CAP (1 cycle): push link_data_i into the RX FIFO. If the FIFO is full, the byte is dropped and rx_ovf_o=1. Set cmd_reg_o[1]=1, go to R_CLR.
  - R_CLR: hold cmd_reg_o[1]=1 until upd_s=0, then cmd_reg_o[1]=0, go to R_IDLE.
- TX and RX FSMs are independent. Both cmd bits may be high in the same cycle.
- err_clr_i vs. a same-cycle error set: the set wins.

Test Plan:
- Reset, then push 0xA5 -> cmd_reg_o[0] rises within 3 cycles with link_data_o=0xA5. Model raises busy 2 cycles later -> start drops in the cycle after busy_s=1. Busy falls -> FSM back to T_IDLE; tx_full_o=0 throughout.
- Push 9 bytes 0x01..0x09 with no link activity -> tx_full_o=1 after 8 pushes; 0x09 is ignored. The link then transmits exactly 0x01..0x08 in order.
- Model never raises busy -> cmd_reg_o[0] high for 16 cycles, then low. tx_err_o=1 and the next byte starts. err_clr_i clears tx_err_o.
- Model sets status[1] with link_data_i=0x3C -> RX FIFO holds 0x3C, rx_empty_o=0, and cmd_reg_o[1] pulses until the flag clears. rx_rd_i -> rx_empty_o=1.
- Deliver 9 received bytes without reading -> the first 8 are stored in order, the 9th is dropped, rx_ovf_o=1, and cmd_reg_o[1] still acknowledges it.
- Assert reset_i during T_WAIT with 3 bytes queued -> next cycle all cmd bits are 0, FIFOs are empty, and no further start is issued.

Source files
------------

// File: rtl/link_fifo_bridge_if.sv
// link_fifo_bridge_if: host FIFO port and connection_module register port of the bridge.
interface link_fifo_bridge_if #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_WIDTH  = 8
);
  logic [DATA_WIDTH-1:0] tx_data_i;
  logic                  tx_wr_i;
  logic                  tx_full_o;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  rx_rd_i;
  logic                  rx_empty_o;
  logic                  rx_ovf_o;
  logic                  tx_err_o;
  logic                  err_clr_i;
  logic [REG_WIDTH-1:0]  prescale_i;
  logic [REG_WIDTH-1:0]  pre_reg_o;
  logic [REG_WIDTH-1:0]  cmd_reg_o;
  logic [REG_WIDTH-1:0]  status_reg_i;
  logic [DATA_WIDTH-1:0] link_data_o;
  logic [DATA_WIDTH-1:0] link_data_i;
  modport slave (
    input  tx_data_i, tx_wr_i, rx_rd_i, err_clr_i, prescale_i, status_reg_i, link_data_i,
    output tx_full_o, rx_data_o, rx_empty_o, rx_ovf_o, tx_err_o, pre_reg_o, cmd_reg_o, link_data_o
  );
  modport master (
    output tx_data_i, tx_wr_i, rx_rd_i, err_clr_i, prescale_i, status_reg_i, link_data_i,
    input  tx_full_o, rx_data_o, rx_empty_o, rx_ovf_o, tx_err_o, pre_reg_o, cmd_reg_o, link_data_o
  );
endinterface

// File: rtl/link_fifo_bridge.sv
// link_fifo_bridge: TX/RX byte FIFOs feeding and draining connection_module via cmd/status registers.
module link_fifo_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int START_TO   = 16
) (
  input logic clk_i,
  input logic reset_i,
  link_fifo_bridge_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW = $clog2(START_TO) + 1;
  typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_CAP, R_CLR} rx_state_t;
  tx_state_t tx_state;
  rx_state_t rx_state;
  logic [1:0] busy_q, upd_q;
  logic busy_s, upd_s, cmd_start, cmd_ack, tx_err, rx_ovf, unused_status;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
  logic [DATA_WIDTH-1:0] link_data, rx_head;
  logic [REG_WIDTH-1:0] pre_reg;
  logic [ADDR_WIDTH:0] tx_wp, tx_rp, rx_wp, rx_rp, rx_rp_n;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop;
  logic tx_err_set, rx_ovf_set;
  assign busy_s = busy_q[1];
  assign upd_s = upd_q[1];
  assign unused_status = ^bus.status_reg_i[REG_WIDTH-1:2];
  assign tx_full = tx_wp == {~tx_rp[ADDR_WIDTH], tx_rp[ADDR_WIDTH-1:0]};
  assign tx_empty = tx_wp == tx_rp;
  assign rx_full = rx_wp == {~rx_rp[ADDR_WIDTH], rx_rp[ADDR_WIDTH-1:0]};
  assign rx_empty = rx_wp == rx_rp;
  assign tx_push = bus.tx_wr_i && !tx_full;
  assign tx_pop = tx_state == T_IDLE && !tx_empty && !busy_s;
  assign rx_push = rx_state == R_CAP && !rx_full;
  assign rx_pop = bus.rx_rd_i && !rx_empty;
  assign rx_rp_n = rx_rp + (ADDR_WIDTH + 1)'(rx_pop);
  assign tx_err_set = tx_state == T_START && !busy_s && cnt == CW'(START_TO - 1);
  assign rx_ovf_set = rx_state == R_CAP && rx_full;
  assign bus.tx_full_o = tx_full;
  assign bus.rx_empty_o = rx_empty;
  assign bus.rx_data_o = rx_head;
  assign bus.tx_err_o = tx_err;
  assign bus.rx_ovf_o = rx_ovf;
  assign bus.pre_reg_o = pre_reg;
  assign bus.link_data_o = link_data;
  assign bus.cmd_reg_o = {{(REG_WIDTH-2){1'b0}}, cmd_ack, cmd_start};
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q <= '0;
      upd_q <= '0;
      pre_reg <= '0;
    end else begin
      busy_q <= {busy_q[0], bus.status_reg_i[0]};
      upd_q <= {upd_q[0], bus.status_reg_i[1]};
      pre_reg <= bus.prescale_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wp[ADDR_WIDTH-1:0]] <= bus.tx_data_i;
    if (rx_push) rx_mem[rx_wp[ADDR_WIDTH-1:0]] <= bus.link_data_i;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
    end
  end
  // Head register: loads the pushed byte when it lands in an empty (or just-emptied) FIFO.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_wp <= '0;
      rx_rp <= '0;
      rx_head <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      rx_rp <= rx_rp_n;
      if (rx_push && rx_wp == rx_rp_n) rx_head <= bus.link_data_i;
      else if (rx_pop) rx_head <= rx_mem[rx_rp_n[ADDR_WIDTH-1:0]];
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_state <= T_IDLE;
      cmd_start <= 1'b0;
      link_data <= '0;
      cnt <= '0;
      tx_err <= 1'b0;
    end else begin
      tx_err <= tx_err_set || (tx_err && !bus.err_clr_i);
      case (tx_state)
        T_IDLE: if (tx_pop) begin
          link_data <= tx_mem[tx_rp[ADDR_WIDTH-1:0]];
          cmd_start <= 1'b1;
          cnt <= '0;
          tx_state <= T_START;
        end
        T_START: if (busy_s) begin
          cmd_start <= 1'b0;
          tx_state <= T_WAIT;
        end else if (tx_err_set) begin
          cmd_start <= 1'b0;
          tx_state <= T_IDLE;
        end else cnt <= cnt + 1'b1;
        T_WAIT: if (!busy_s) tx_state <= T_IDLE;
        default: tx_state <= T_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_state <= R_IDLE;
      cmd_ack <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      rx_ovf <= rx_ovf_set || (rx_ovf && !bus.err_clr_i);
      case (rx_state)
        R_IDLE: if (upd_s) rx_state <= R_CAP;
        R_CAP: begin
          cmd_ack <= 1'b1;
          rx_state <= R_CLR;
        end
        R_CLR: if (!upd_s) begin
          cmd_ack <= 1'b0;
          rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_link_fifo_bridge.sv
// tb_link_fifo_bridge: directed checks of FIFO buffering, start/ack handshakes, errors and reset.
module tb_link_fifo_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  link_fifo_bridge_if bus ();
  link_fifo_bridge dut (.clk_i(clk), .reset_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_bit(input int b, input logic v, input string tag);
    int n = 0;
    while (bus.cmd_reg_o[b] !== v && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.cmd_reg_o[b]), 32'(v));
  endtask
  task automatic push(input logic [7:0] d);
    bus.tx_data_i = d;
    bus.tx_wr_i = 1'b1;
    tick();
    bus.tx_wr_i = 1'b0;
  endtask
  initial begin
    int n;
    bus.tx_data_i = '0;
    bus.tx_wr_i = 1'b0;
    bus.rx_rd_i = 1'b0;
    bus.err_clr_i = 1'b0;
    bus.prescale_i = 8'h5A;
    bus.status_reg_i = '0;
    bus.link_data_i = '0;
    tick();
    tick();
    check("rst_full", 32'(bus.tx_full_o), 0);
    check("rst_empty", 32'(bus.rx_empty_o), 1);
    check("rst_rx_data", 32'(bus.rx_data_o), 0);
    check("rst_cmd", 32'(bus.cmd_reg_o), 0);
    check("rst_link", 32'(bus.link_data_o), 0);
    check("rst_pre", 32'(bus.pre_reg_o), 0);
    check("rst_errs", {30'd0, bus.rx_ovf_o, bus.tx_err_o}, 0);
    rst = 1'b0;
    tick();
    check("pre_reg", 32'(bus.pre_reg_o), 32'h5A);
    // single byte with busy handshake
    push(8'hA5);
    n = 0;
    while (!bus.cmd_reg_o[0] && n < 5) begin
      tick();
      n++;
    end
    check("start_rise", 32'(bus.cmd_reg_o[0]), 1);
    check("start_latency", 32'(n), 1);
    check("start_data", 32'(bus.link_data_o), 32'hA5);
    tick();
    tick();
    bus.status_reg_i = 8'h01;
    tick();
    tick();
    check("start_hold", 32'(bus.cmd_reg_o[0]), 1);
    tick();
    check("start_drop", 32'(bus.cmd_reg_o[0]), 0);
    bus.status_reg_i = 8'h00;
    repeat (4) tick();
    check("t1_full", 32'(bus.tx_full_o), 0);
    check("t1_err", 32'(bus.tx_err_o), 0);
    check("t1_cmd", 32'(bus.cmd_reg_o), 0);
    // fill TX FIFO while link is busy
    bus.status_reg_i = 8'h01;
    repeat (3) tick();
    for (int i = 1; i <= 9; i++) begin
      push(8'(i));
      if (i == 7) check("full_at7", 32'(bus.tx_full_o), 0);
      if (i == 8) check("full_at8", 32'(bus.tx_full_o), 1);
    end
    check("no_start_busy", 32'(bus.cmd_reg_o[0]), 0);
    bus.status_reg_i = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      wait_bit(0, 1'b1, "tx_start");
      check("tx_order", 32'(bus.link_data_o), 32'(i));
      bus.status_reg_i = 8'h01;
      wait_bit(0, 1'b0, "tx_busy_ack");
      bus.status_reg_i = 8'h00;
    end
    n = 0;
    repeat (30) begin
      tick();
      if (bus.cmd_reg_o[0]) n++;
    end
    check("ninth_dropped", 32'(n), 0);
    check("t2_err", 32'(bus.tx_err_o), 0);
    // start timeout
    push(8'h11);
    push(8'h22);
    wait_bit(0, 1'b1, "to_start");
    check("to_data", 32'(bus.link_data_o), 32'h11);
    n = 0;
    while (bus.cmd_reg_o[0] && n < 40) begin
      n++;
      tick();
    end
    check("to_len", 32'(n), 16);
    check("to_err", 32'(bus.tx_err_o), 1);
    tick();
    check("to_next_start", 32'(bus.cmd_reg_o[0]), 1);
    check("to_next_data", 32'(bus.link_data_o), 32'h22);
    bus.status_reg_i = 8'h01;
    wait_bit(0, 1'b0, "to_next_ack");
    bus.status_reg_i = 8'h00;
    repeat (4) tick();
    check("err_sticky", 32'(bus.tx_err_o), 1);
    bus.err_clr_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b0;
    check("err_clr", 32'(bus.tx_err_o), 0);
    // single receive
    bus.link_data_i = 8'h3C;
    bus.status_reg_i = 8'h02;
    wait_bit(1, 1'b1, "rx_ack");
    check("rx_not_empty", 32'(bus.rx_empty_o), 0);
    check("rx_head", 32'(bus.rx_data_o), 32'h3C);
    repeat (3) tick();
    check("rx_ack_hold", 32'(bus.cmd_reg_o[1]), 1);
    bus.status_reg_i = 8'h00;
    wait_bit(1, 1'b0, "rx_ack_drop");
    bus.rx_rd_i = 1'b1;
    tick();
    bus.rx_rd_i = 1'b0;
    check("rx_pop_empty", 32'(bus.rx_empty_o), 1);
    check("rx_no_ovf", 32'(bus.rx_ovf_o), 0);
    // RX overflow
    for (int i = 0; i < 9; i++) begin
      bus.link_data_i = 8'(8'h40 + i);
      bus.status_reg_i = 8'h02;
      wait_bit(1, 1'b1, "ovf_ack");
      bus.status_reg_i = 8'h00;
      wait_bit(1, 1'b0, "ovf_ack_drop");
      if (i == 7) check("ovf_at8", 32'(bus.rx_ovf_o), 0);
    end
    check("ovf_at9", 32'(bus.rx_ovf_o), 1);
    check("ovf_not_empty", 32'(bus.rx_empty_o), 0);
    bus.rx_rd_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("rx_order", 32'(bus.rx_data_o), 32'(8'h40 + i));
      tick();
    end
    bus.rx_rd_i = 1'b0;
    check("rx_drained", 32'(bus.rx_empty_o), 1);
    bus.err_clr_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b0;
    check("ovf_clr", 32'(bus.rx_ovf_o), 0);
    // reset during T_WAIT with queued bytes
    push(8'h71);
    wait_bit(0, 1'b1, "r_start");
    bus.status_reg_i = 8'h01;
    wait_bit(0, 1'b0, "r_wait");
    bus.link_data_i = 8'h99;
    bus.status_reg_i = 8'h03;
    wait_bit(1, 1'b1, "r_rx_ack");
    push(8'h81);
    push(8'h82);
    push(8'h83);
    check("r_pre_empty", 32'(bus.rx_empty_o), 0);
    rst = 1'b1;
    tick();
    check("r_cmd", 32'(bus.cmd_reg_o), 0);
    check("r_rx_empty", 32'(bus.rx_empty_o), 1);
    check("r_link", 32'(bus.link_data_o), 0);
    check("r_full", 32'(bus.tx_full_o), 0);
    rst = 1'b0;
    bus.status_reg_i = 8'h00;
    n = 0;
    repeat (25) begin
      tick();
      if (bus.cmd_reg_o != 8'h00) n++;
    end
    check("r_no_start", 32'(n), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
